// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit and the core's writeback path.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD,
        WR,
        RMW_RD,
        RMW_WR,
        ERR
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size in bytes; 0 marks a funct3 that is illegal for this access kind.
    function automatic logic [2:0] access_size(input logic is_store, input logic [2:0] funct3);
        logic [2:0] size;
        size = 3'd0;
        case (funct3)
            F3_B:    size = 3'd1;
            F3_H:    size = 3'd2;
            F3_W:    size = 3'd4;
            F3_BU:   size = is_store ? 3'd0 : 3'd1;
            F3_HU:   size = is_store ? 3'd0 : 3'd2;
            default: size = 3'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a little-endian word and sign- or zero-extends it.
module load_align
    import lsu_pkg::*;
#(
    parameter int addr_data_width = 32
) (
    input  logic [addr_data_width-1:0] word,
    input  logic [1:0]                 lane,
    input  logic [2:0]                 funct3,
    output logic [addr_data_width-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        result = '0;
        case (funct3)
            F3_B:    result = {{(addr_data_width-8){byte_sel[7]}}, byte_sel};
            F3_H:    result = {{(addr_data_width-16){half_sel[15]}}, half_sel};
            F3_W:    result = word;
            F3_BU:   result = {{(addr_data_width-8){1'b0}}, byte_sel};
            F3_HU:   result = {{(addr_data_width-16){1'b0}}, half_sel};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: validates a request, then drives a word-wide memory port,
// turning SB/SH into a read-modify-write pair.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int addr_data_width = 32,
    parameter int memory_height   = 2048
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_is_store,
    input  logic [2:0]                 req_funct3,
    input  logic [addr_data_width-1:0] req_addr,
    input  logic [addr_data_width-1:0] req_wdata,
    output logic                       resp_valid,
    output logic                       resp_err,
    output logic [addr_data_width-1:0] resp_rdata,
    output logic                       mem_r_en,
    output logic                       mem_wr_en,
    output logic [addr_data_width-1:0] mem_addr,
    output logic [addr_data_width-1:0] mem_wdata,
    input  logic [addr_data_width-1:0] mem_rdata
);

    localparam int AW1 = addr_data_width + 1;

    lsu_state_t                 state_reg;
    logic [addr_data_width-1:0] addr_reg;
    logic [addr_data_width-1:0] wdata_reg;
    logic [addr_data_width-1:0] merge_reg;
    logic [2:0]                 funct3_reg;

    logic [2:0]                 req_size;
    logic [AW1-1:0]             req_end_addr;
    logic                       req_misaligned;
    logic                       req_out_of_range;
    logic                       req_err;
    logic [addr_data_width-1:0] word_addr;
    logic [addr_data_width-1:0] load_data;
    logic [addr_data_width-1:0] merged;

    // One extra bit keeps the last-byte address from wrapping near the top of the address space.
    assign req_size         = access_size(req_is_store, req_funct3);
    assign req_end_addr     = {1'b0, req_addr} + AW1'(req_size) - AW1'(1);
    assign req_misaligned   = (req_size == 3'd2 && req_addr[0]) ||
                              (req_size == 3'd4 && req_addr[1:0] != 2'b00);
    assign req_out_of_range = req_end_addr >= AW1'(memory_height);
    assign req_err          = (req_size == 3'd0) || req_misaligned || req_out_of_range;

    assign word_addr = {addr_reg[addr_data_width-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            merge_reg  <= '0;
            funct3_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        funct3_reg <= req_funct3;
                        if (req_err)
                            state_reg <= ERR;
                        else if (!req_is_store)
                            state_reg <= LD;
                        else if (req_size == 3'd4)
                            state_reg <= WR;
                        else
                            state_reg <= RMW_RD;
                    end
                end
                RMW_RD: begin
                    merge_reg <= mem_rdata;
                    state_reg <= RMW_WR;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Byte lanes not covered by the store keep the word read back in RMW_RD.
    genvar gi;
    generate
        for (gi = 0; gi < addr_data_width / 8; gi++) begin : g_merge
            if (gi < 4) begin : g_lane
                logic hit_b;
                logic hit_h;
                assign hit_b = (funct3_reg == F3_B) && (addr_reg[1:0] == 2'(gi));
                assign hit_h = (funct3_reg == F3_H) && (addr_reg[1] == 1'(gi / 2));
                assign merged[8*gi +: 8] = hit_h ? wdata_reg[8*(gi%2) +: 8] :
                                           hit_b ? wdata_reg[7:0] :
                                                   merge_reg[8*gi +: 8];
            end else begin : g_pass
                assign merged[8*gi +: 8] = merge_reg[8*gi +: 8];
            end
        end
    endgenerate

    load_align #(
        .addr_data_width(addr_data_width)
    ) u_load_align (
        .word   (mem_rdata),
        .lane   (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .result (load_data)
    );

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_r_en   = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!rst) begin
            case (state_reg)
                IDLE: req_ready = 1'b1;
                LD: begin
                    mem_r_en   = 1'b1;
                    mem_addr   = word_addr;
                    resp_valid = 1'b1;
                    resp_rdata = load_data;
                end
                WR: begin
                    mem_wr_en  = 1'b1;
                    mem_addr   = word_addr;
                    mem_wdata  = wdata_reg;
                    resp_valid = 1'b1;
                end
                RMW_RD: begin
                    mem_r_en = 1'b1;
                    mem_addr = word_addr;
                end
                RMW_WR: begin
                    mem_wr_en  = 1'b1;
                    mem_addr   = word_addr;
                    mem_wdata  = merged;
                    resp_valid = 1'b1;
                end
                ERR: begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized traffic against a byte-array model,
// and hand-written reset sequences.
module tb_load_store_unit;

    localparam int W  = 32;
    localparam int MH = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_store;
    logic [2:0]    req_funct3;
    logic [W-1:0]  req_addr;
    logic [W-1:0]  req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [W-1:0]  resp_rdata;
    logic          mem_r_en;
    logic          mem_wr_en;
    logic [W-1:0]  mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(
        .addr_data_width(W),
        .memory_height  (MH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_r_en     (mem_r_en),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Word-wide data memory stand-in, preloaded with a deterministic pattern while preload=1.
    logic [31:0] mem [0:MH/4-1];
    logic        preload;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    assign mem_rdata = mem_r_en ? mem[mem_addr[10:2]] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MH / 4; i++) mem[i] <= init_word(i);
        end else if (mem_wr_en) begin
            mem[mem_addr[10:2]] <= mem_wdata;
        end
    end

    // Reference model: plain byte array, little-endian.
    logic [7:0] ref_mem [0:MH-1];
    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd,
                         output int lat, output int rdc, output int wrc,
                         output logic [31:0] word_after);
        int size;
        logic sgn;
        logic [31:0] v;
        logic [31:0] mask;
        int base;
        size = 0;
        sgn  = 1'b0;
        if (!st) begin
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: size = 0;
            endcase
        end else begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: size = 0;
            endcase
        end
        if (size == 0) err = 1'b1;
        else err = ((a % size) != 0) || ((longint'(a) + size - 1) >= MH);
        rd = 32'h0;
        word_after = 32'h0;
        if (err) begin
            lat = 1; rdc = 0; wrc = 0;
        end else if (!st) begin
            lat = 1; rdc = 1; wrc = 0;
            v = 32'h0;
            for (int k = 0; k < size; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
            if (size < 4) begin
                mask = (32'h1 << (8 * size)) - 32'h1;
                if (sgn && v[8*size-1]) v = v | ~mask;
            end
            rd = v;
        end else begin
            for (int k = 0; k < size; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            lat = (size == 4) ? 1 : 2;
            rdc = (size == 4) ? 0 : 1;
            wrc = 1;
            base = int'(a) & ~3;
            for (int k = 0; k < 4; k++) word_after[8*k +: 8] = ref_mem[base + k];
        end
    endtask

    // Issue one request and observe the DUT until the cycle after its response.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic g_err, output logic [31:0] g_rd,
                          output int g_lat, output int g_rdc, output int g_wrc,
                          output logic [31:0] g_wword, output int busy, output logic ready_after,
                          output logic resp_again, output logic bad_addr, output logic both,
                          output logic timeout);
        logic done;
        g_err = 1'b0; g_rd = 32'h0; g_lat = 0; g_rdc = 0; g_wrc = 0; g_wword = 32'h0;
        busy = 0; ready_after = 1'b0; resp_again = 1'b0; bad_addr = 1'b0; both = 1'b0;
        timeout = 1'b0; done = 1'b0;
        for (int i = 0; i < 10 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) begin
            timeout = 1'b1;
            return;
        end
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        // Garbage on the request bus while busy must be ignored.
        req_valid = 1'b0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 6; c++) begin
            if (mem_r_en) g_rdc++;
            if (mem_wr_en) begin g_wrc++; g_wword = mem_wdata; end
            if ((mem_r_en || mem_wr_en) && mem_addr != {a[31:2], 2'b00}) bad_addr = 1'b1;
            if (mem_r_en && mem_wr_en) both = 1'b1;
            if (!req_ready) busy++;
            if (resp_valid) begin
                g_lat = c; g_err = resp_err; g_rd = resp_rdata; done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            timeout = 1'b1;
            return;
        end
        @(posedge clk); #1;
        ready_after = req_ready;
        resp_again  = resp_valid;
    endtask

    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic use_tab, input logic t_err,
                           input logic [31:0] t_rd, input int t_lat);
        logic m_err; logic [31:0] m_rd; int m_lat; int m_rdc; int m_wrc; logic [31:0] m_word;
        logic g_err; logic [31:0] g_rd; int g_lat; int g_rdc; int g_wrc; logic [31:0] g_wword;
        int busy; logic ready_after; logic resp_again; logic bad_addr; logic both; logic timeout;
        logic e_err; logic [31:0] e_rd; int e_lat;
        model(st, f3, a, wd, m_err, m_rd, m_lat, m_rdc, m_wrc, m_word);
        e_err = use_tab ? t_err : m_err;
        e_rd  = use_tab ? t_rd  : m_rd;
        e_lat = use_tab ? t_lat : m_lat;
        do_req(st, f3, a, wd, g_err, g_rd, g_lat, g_rdc, g_wrc, g_wword, busy, ready_after,
               resp_again, bad_addr, both, timeout);
        txn_no++;
        $display("txn %0d: %s f3=%0d addr=%h wdata=%h -> err=%0b rdata=%h lat=%0d (exp err=%0b rdata=%h lat=%0d)",
                 txn_no, st ? "store" : "load ", f3, a, wd, g_err, g_rd, g_lat, e_err, e_rd, e_lat);
        check("timeout", 32'(timeout), 32'h0);
        if (timeout) return;
        check("resp_err", 32'(g_err), 32'(e_err));
        check("resp_rdata", g_rd, e_rd);
        check("latency", 32'(g_lat), 32'(e_lat));
        check("rd_cycles", 32'(g_rdc), 32'(m_rdc));
        check("wr_cycles", 32'(g_wrc), 32'(m_wrc));
        if (m_wrc != 0) check("mem_wdata", g_wword, m_word);
        check("busy_cycles", 32'(busy), 32'(e_lat));
        check("ready_after", 32'(ready_after), 32'h1);
        check("resp_once", 32'(resp_again), 32'h0);
        check("mem_addr", 32'(bad_addr), 32'h0);
        check("rw_exclusive", 32'(both), 32'h0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {27'h0, req_ready, resp_valid, resp_err, mem_r_en, mem_wr_en}, 32'h0);
        check({name, "_data"}, resp_rdata | mem_addr | mem_wdata, 32'h0);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t tab[$];

    initial begin
        logic [31:0] w;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;

        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < MH; i++) begin
            w = init_word(i / 4);
            ref_mem[i] = w[8*(i%4) +: 8];
        end

        @(posedge clk); #1;
        check_outputs_zero("reset_outputs");
        @(posedge clk); #1;
        preload = 1'b0; rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'h1);

        //          st    f3    addr           wdata          err   rdata          lat
        tab.push_back('{1'b1, 3'd2, 32'h0000_0010, 32'h80FF_7F01, 1'b0, 32'h0000_0000, 1});
        tab.push_back('{1'b0, 3'd0, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FF80, 1});
        tab.push_back('{1'b0, 3'd5, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_80FF, 1});
        tab.push_back('{1'b1, 3'd0, 32'h0000_0011, 32'hAAAA_AA55, 1'b0, 32'h0000_0000, 2});
        tab.push_back('{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'h80FF_5501, 1});
        tab.push_back('{1'b0, 3'd1, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_80FF, 1});
        tab.push_back('{1'b0, 3'd2, 32'h0000_0012, 32'h0,         1'b1, 32'h0000_0000, 1});
        tab.push_back('{1'b1, 3'd1, 32'h0000_0021, 32'h1234_5678, 1'b1, 32'h0000_0000, 1});
        tab.push_back('{1'b0, 3'd0, 32'h0000_0800, 32'h0,         1'b1, 32'h0000_0000, 1});
        tab.push_back('{1'b0, 3'd3, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0000, 1});
        tab.push_back('{1'b1, 3'd2, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1});
        tab.push_back('{1'b0, 3'd2, 32'h0000_0020, 32'h0,         1'b0, 32'hDEAD_BEEF, 1});
        tab.push_back('{1'b1, 3'd2, 32'h0000_07FC, 32'h1234_5678, 1'b0, 32'h0000_0000, 1});
        tab.push_back('{1'b0, 3'd5, 32'h0000_07FE, 32'h0,         1'b0, 32'h0000_1234, 1});
        tab.push_back('{1'b0, 3'd1, 32'h0000_07FF, 32'h0,         1'b1, 32'h0000_0000, 1});
        tab.push_back('{1'b0, 3'd4, 32'h0000_07FF, 32'h0,         1'b0, 32'h0000_0012, 1});
        tab.push_back('{1'b1, 3'd2, 32'h0000_07FE, 32'h0,         1'b1, 32'h0000_0000, 1});
        tab.push_back('{1'b1, 3'd4, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0000, 1});
        tab.push_back('{1'b1, 3'd1, 32'h0000_07FE, 32'hFFFF_8001, 1'b0, 32'h0000_0000, 2});
        tab.push_back('{1'b0, 3'd1, 32'h0000_07FE, 32'h0,         1'b0, 32'hFFFF_8001, 1});
        tab.push_back('{1'b0, 3'd2, 32'h0000_07FC, 32'h0,         1'b0, 32'h8001_5678, 1});
        tab.push_back('{1'b1, 3'd2, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000, 1});
        tab.push_back('{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0000_0000, 1});

        foreach (tab[i])
            run_txn(tab[i].st, tab[i].f3, tab[i].addr, tab[i].wdata, 1'b1,
                    tab[i].exp_err, tab[i].exp_rd, tab[i].exp_lat);

        // Reset during the read half of an SH must drop the write entirely.
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd1;
        req_addr = 32'h30; req_wdata = 32'h0000_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_rd_active", 32'(mem_r_en), 32'h1);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_rmw_reset");
        @(posedge clk); #1;
        check_outputs_zero("reset_held");
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rmw_reset", 32'(req_ready), 32'h1);
        $display("txn %0d: reset asserted during SH RMW_RD at 0x30", ++txn_no);
        run_txn(1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            st = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            if (r == 0) f3 = 3'($urandom_range(0, 7));
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            r = int'($urandom_range(0, 9));
            if (r < 6) a = 32'($urandom_range(0, 63));
            else if (r < 9) a = 32'($urandom_range(2032, 2063));
            else a = $urandom;
            run_txn(st, f3, a, $urandom, 1'b0, 1'b0, 32'h0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the single-cycle core's execute stage and `data_memory`. It accepts one load or store per request, sizes it as byte, half or word, and checks alignment and range. Sub-word stores become a read-modify-write pair, because the memory port writes whole words only. Loaded data is returned sign- or zero-extended, and the core stalls on `req_ready` until the response arrives.

## Interface
- `addr_data_width`, 32, data and address width
- `memory_height`, 2048, memory size in bytes; legal byte addresses are 0 .. memory_height-1
- `clk` input 1, rising-edge clock
- `rst` input 1, synchronous reset, active-high (one clock; reset is synchronous and active-high)
- `req_valid` input 1, core presents a request
- `req_ready` output 1, unit can accept a request
- `req_is_store` input 1, 1 = store, 0 = load
- `req_funct3` input 3, RISC-V funct3 (size and signedness)
- `req_addr` input addr_data_width, byte address
- `req_wdata` input addr_data_width, store data (low bytes used for SB/SH)
- `resp_valid` output 1, response this cycle
- `resp_err` output 1, misaligned, out-of-range or illegal funct3
- `resp_rdata` output addr_data_width, formatted load data (0 for stores and errors)
- `mem_r_en` output 1, memory read enable
- `mem_wr_en` output 1, memory write enable (memory writes at next rising edge)
- `mem_addr` output addr_data_width, word-aligned address (bits [1:0] = 0)
- `mem_wdata` output addr_data_width, full word to write
- `mem_rdata` input addr_data_width, memory read data, combinational from `mem_addr` while `mem_r_en`=1

## Operation
- **funct3 decode**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- **Error conditions**
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - addr+size-1 ≥ memory_height.
  - Illegal funct3.
- **Registers.** Request fields are captured on acceptance (`req_valid && req_ready`). `req_*` inputs are ignored in every other cycle.
- **Byte order.** Little-endian. Byte lane = addr[1:0]; halfword lane = addr[1].
- **States and transitions**
  - IDLE: `req_ready`=1.
    - Accept, then go to ERR if any error condition holds.
    - Otherwise a load goes to LD, SW goes to WR, SB/SH go to RMW_RD.
  - LD: `mem_r_en`=1. Select the addressed lane, extend it (LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through) and drive `resp_valid`=1. Go to IDLE.
  - WR: `mem_wr_en`=1, `mem_wdata`=req_wdata, `resp_valid`=1. Go to IDLE.
  - RMW_RD: `mem_r_en`=1. Capture `mem_rdata` into the merge register. Go to RMW_WR.
  - RMW_WR: `mem_wr_en`=1. `mem_wdata` = merge register with the addressed byte or half replaced by req_wdata[7:0] or [15:0]; all other bytes are unchanged. `resp_valid`=1. Go to IDLE.
  - ERR: `resp_valid`=1, `resp_err`=1, no memory enable. Go to IDLE.
- `mem_addr` = {req_addr[addr_data_width-1:2], 2'b00} in LD, WR, RMW_RD and RMW_WR; 0 otherwise.
- `mem_r_en` and `mem_wr_en` are never high in the same cycle.

## Timing
- **Reset.** Next state = IDLE. While `rst`=1 all outputs are 0, including `req_ready`. Reset wins over any in-flight state; an interrupted RMW leaves memory unwritten.
- **Latency from acceptance edge to `resp_valid`**
  - Loads, SW and errors: 1 cycle.
  - SB/SH: 2 cycles.
- **Back-to-back.** `resp_valid` is 1 for exactly one cycle. IDLE is re-entered the next cycle, so sustained throughput is one load per 2 cycles and one SB/SH per 3 cycles.
- **Load data.** `resp_rdata` is combinational from `mem_rdata` during LD. It is valid only while `resp_valid`=1 and is held at 0 otherwise.
- **Memory write.** Committed at the rising edge that ends WR or RMW_WR. A load issued immediately afterwards reads the new data.

## Structure
- Package `lsu_pkg` holds:
  - the state enum (IDLE, LD, WR, RMW_RD, RMW_WR, ERR);
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the size-decode function.
- Sub-module `load_align` is combinational: word, addr[1:0] and funct3 in; extended result out. It is reused in the core's writeback path.

## Test plan
- **LB sign-extension.** Memory word at 0x10 = 0x80FF7F01; LB addr 0x13 → `resp_rdata`=0xFFFFFF80, 1 cycle after accept, `resp_err`=0.
- **LHU zero-extension.** Same word; LHU addr 0x12 → 0x000080FF.
- **SB read-modify-write.** SB addr 0x11, wdata 0xAAAAAA55 → `mem_r_en` for one cycle, then `mem_wr_en` with `mem_wdata`=0x80FF5501. Resp after 2 cycles; a subsequent LW 0x10 returns 0x80FF5501.
- **Error cases.** LW 0x12, SH 0x21, LB 0x800 (memory_height=2048) and load funct3 011 → each gives `resp_err`=1 after 1 cycle, `mem_r_en`=`mem_wr_en`=0 throughout, `resp_rdata`=0.
- **Back-to-back.** SW 0x20 = 0xDEADBEEF followed immediately by LW 0x20 → the load returns 0xDEADBEEF; `req_ready` is low for exactly one cycle after each accept.
- **Reset mid-RMW.** Assert `rst` in the RMW_RD cycle of an SH → no write occurs, all outputs are 0 during reset, and the unit returns to IDLE with `req_ready`=1 the cycle after `rst` falls.
